// File: rtl/hazard_scoreboard.sv
// In-order issue interlock: tracks in-flight destination registers for WB_LAT cycles,
// stalls decode on read-after-write hazards and drives the delayed register-file write port.
module hazard_scoreboard #(
    parameter int ADDR_W    = 5,
    parameter int WB_LAT    = 3,
    parameter int BYPASS_WB = 0,
    parameter int ZERO_REG  = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_we,
    input  logic              flush,
    input  logic              stat_clr,
    output logic              stall,
    output logic              issue_fire,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count
);

    // Handshake: decode offers an instruction while issue_valid is high and it is taken
    // exactly in a cycle with issue_fire high; while stall is high decode holds the same
    // instruction; flush withdraws it in that cycle without it ever being taken.

    // The entry in its writeback cycle is skipped when the regfile writes before it reads.
    localparam int CHECK_N = (BYPASS_WB != 0) ? WB_LAT - 1 : WB_LAT;

    logic [WB_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_rd [WB_LAT];

    logic              hit1;
    logic              hit2;
    logic              load_v;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < CHECK_N; k++) begin
            if (pipe_v[k] && (pipe_rd[k] == rs1)) hit1 = 1'b1;
            if (pipe_v[k] && (pipe_rd[k] == rs2)) hit2 = 1'b1;
        end
        if (!use_rs1 || ((ZERO_REG != 0) && (rs1 == '0))) hit1 = 1'b0;
        if (!use_rs2 || ((ZERO_REG != 0) && (rs2 == '0))) hit2 = 1'b0;
    end

    // Gating with reset keeps both strobes low while the scoreboard is being cleared.
    assign stall      = ~reset & issue_valid & ~flush & (hit1 | hit2);
    assign issue_fire = ~reset & issue_valid & ~flush & ~(hit1 | hit2);
    assign load_v     = issue_fire & rd_we & ~((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_v <= '0;
            for (int k = 0; k < WB_LAT; k++) pipe_rd[k] <= '0;
        end else begin
            for (int k = WB_LAT - 1; k > 0; k--) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_rd[k] <= pipe_rd[k-1];
            end
            pipe_v[0]  <= load_v;
            pipe_rd[0] <= load_v ? rd : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign wb_valid = pipe_v[WB_LAT-1];
    assign wb_rd    = pipe_rd[WB_LAT-1];
    assign busy     = |pipe_v;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four configurations driven in lockstep (default, bypass,
// no zero register, 4-bit counter) against a per-cycle issue-history model.
module tb_hazard_scoreboard;

    localparam int LAT  = 3;
    localparam int HIST = 4096;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- shared stimulus ----------------
    logic       issue_valid = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       use_rs1 = 1'b0, use_rs2 = 1'b0, rd_we = 1'b0;
    logic       flush = 1'b0, stat_clr = 1'b0;

    logic st0, st1, st2, st3, fi0, fi1, fi2, fi3;
    logic wv0, wv1, wv2, wv3, bz0, bz1, bz2, bz3;
    logic [4:0]  wr0, wr1, wr2, wr3;
    logic [15:0] sc0, sc1, sc2;
    logic [3:0]  sc3;

    hazard_scoreboard u_def (.clock(clock), .reset(reset), .issue_valid(issue_valid),
        .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .rd_we(rd_we),
        .flush(flush), .stat_clr(stat_clr), .stall(st0), .issue_fire(fi0), .wb_valid(wv0),
        .wb_rd(wr0), .busy(bz0), .stall_count(sc0));

    hazard_scoreboard #(.BYPASS_WB(1)) u_byp (.clock(clock), .reset(reset),
        .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd(rd), .rd_we(rd_we), .flush(flush), .stat_clr(stat_clr), .stall(st1),
        .issue_fire(fi1), .wb_valid(wv1), .wb_rd(wr1), .busy(bz1), .stall_count(sc1));

    hazard_scoreboard #(.ZERO_REG(0)) u_nzr (.clock(clock), .reset(reset),
        .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd(rd), .rd_we(rd_we), .flush(flush), .stat_clr(stat_clr), .stall(st2),
        .issue_fire(fi2), .wb_valid(wv2), .wb_rd(wr2), .busy(bz2), .stall_count(sc2));

    hazard_scoreboard #(.CNT_W(4)) u_c4 (.clock(clock), .reset(reset),
        .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd(rd), .rd_we(rd_we), .flush(flush), .stat_clr(stat_clr), .stall(st3),
        .issue_fire(fi3), .wb_valid(wv3), .wb_rd(wr3), .busy(bz3), .stall_count(sc3));

    logic [3:0]       st_v, fi_v, wv_v, bz_v;
    logic [3:0][4:0]  wr_v;
    logic [3:0][15:0] sc_v;
    assign st_v = {st3, st2, st1, st0};
    assign fi_v = {fi3, fi2, fi1, fi0};
    assign wv_v = {wv3, wv2, wv1, wv0};
    assign bz_v = {bz3, bz2, bz1, bz0};
    assign wr_v = {wr3, wr2, wr1, wr0};
    assign sc_v = {{12'd0, sc3}, sc2, sc1, sc0};

    // ---------------- reference model ----------------
    // rec_v[c][n]: configuration c accepted a register write in cycle n (to rec_rd[c][n]).
    bit         rec_v  [4][HIST];
    logic [4:0] rec_rd [4][HIST];
    int         cnt    [4];
    logic [4:0] exp_q[$];

    int checks = 0;
    int failures = 0;

    function automatic bit cfg_byp(int c); return c == 1; endfunction
    function automatic bit cfg_zr(int c);  return c != 2; endfunction
    function automatic int cfg_max(int c); return (c == 3) ? 15 : 65535; endfunction

    function automatic bit model_hit(int c, logic [4:0] src);
        int lo;
        lo = cyc - LAT + (cfg_byp(c) ? 1 : 0);
        if (cfg_zr(c) && src == 5'd0) return 1'b0;
        for (int n = lo; n < cyc; n++)
            if (n >= 0 && rec_v[c][n] && rec_rd[c][n] == src) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            cnt[c] = 0;
            for (int n = 0; n < HIST; n++) begin
                rec_v[c][n]  = 1'b0;
                rec_rd[c][n] = '0;
            end
        end
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub, input logic [4:0] d,
                         input logic we, input logic fl, input logic clr);
        issue_valid = iv; rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub;
        rd = d; rd_we = we; flush = fl; stat_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: compare every configuration at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        bit         hz, e_st, e_fi, e_wv, e_bz, wr_ok;
        logic [4:0] e_wr;
        @(negedge clock);
        if (wv0 === 1'b1) begin
            if (exp_q.size() == 0) chk("wb_spurious", 32'(wv0), 32'd0);
            else chk("wb_order", 32'(wr0), 32'(exp_q.pop_front()));
        end
        for (int c = 0; c < 4; c++) begin
            hz   = (use_rs1 && model_hit(c, rs1)) || (use_rs2 && model_hit(c, rs2));
            e_st = issue_valid && !flush && hz;
            e_fi = issue_valid && !flush && !hz;
            e_wv = (cyc >= LAT) ? rec_v[c][cyc-LAT] : 1'b0;
            e_wr = e_wv ? rec_rd[c][cyc-LAT] : 5'd0;
            e_bz = 1'b0;
            for (int n = cyc - LAT; n < cyc; n++) if (n >= 0 && rec_v[c][n]) e_bz = 1'b1;
            chk($sformatf("stall_c%0d", c), 32'(st_v[c]), 32'(e_st));
            chk($sformatf("fire_c%0d", c), 32'(fi_v[c]), 32'(e_fi));
            chk($sformatf("wb_valid_c%0d", c), 32'(wv_v[c]), 32'(e_wv));
            chk($sformatf("wb_rd_c%0d", c), 32'(wr_v[c]), 32'(e_wr));
            chk($sformatf("busy_c%0d", c), 32'(bz_v[c]), 32'(e_bz));
            chk($sformatf("count_c%0d", c), 32'(sc_v[c]), 32'(cnt[c]));
            wr_ok = e_fi && rd_we && !(cfg_zr(c) && rd == 5'd0);
            rec_v[c][cyc]  = wr_ok;
            rec_rd[c][cyc] = wr_ok ? rd : 5'd0;
            if (c == 0 && wr_ok) exp_q.push_back(rd);
            if (stat_clr) cnt[c] = 0;
            else if (e_st && cnt[c] < cfg_max(c)) cnt[c] = cnt[c] + 1;
        end
        @(posedge clock);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds two edges, releases.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_stall_c%0d", c), 32'(st_v[c]), 32'd0);
            chk($sformatf("rst_fire_c%0d", c), 32'(fi_v[c]), 32'd0);
            chk($sformatf("rst_wbv_c%0d", c), 32'(wv_v[c]), 32'd0);
            chk($sformatf("rst_wbrd_c%0d", c), 32'(wr_v[c]), 32'd0);
            chk($sformatf("rst_busy_c%0d", c), 32'(bz_v[c]), 32'd0);
            chk($sformatf("rst_cnt_c%0d", c), 32'(sc_v[c]), 32'd0);
        end
        model_clear();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int k;
        model_clear();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        do_reset();

        // RAW on r9 then r10, reset while writes are in flight and counter is 5.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) step();
        chk("raw_cnt_nobyp", 32'(sc0), 32'd3);
        chk("raw_cnt_byp", 32'(sc1), 32'd2);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        chk("pre_rst_cnt", 32'(sc0), 32'd5);
        chk("pre_rst_busy", 32'(bz0), 32'd1);
        do_reset();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_wb", 32'(wv0), 32'd0);
            step();
        end

        // Back-to-back independent writes r1, r2, r3.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            chk("b2b_wbv", 32'(wv0), 32'd1);
            chk("b2b_wbrd", 32'(wr0), 32'(i));
            step();
        end
        chk("b2b_busy_fall", 32'(bz0), 32'd0);
        chk("b2b_wbv_fall", 32'(wv0), 32'd0);

        // Zero register: write r0, then read it through rs2.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) step();
        chk("zero_cnt_zr1", 32'(sc0), 32'd0);
        chk("zero_cnt_zr0", 32'(sc2), 32'd3);

        // Flush in the second stall cycle of a consumer of r7.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_stall", 32'(st0), 32'd0);
        chk("flush_fire", 32'(fi0), 32'd0);
        step();
        idle();
        repeat (3) step();
        chk("flush_cnt", 32'(sc0), 32'd1);

        // Self-dependent r3 stream: stall pattern 1 fire + 3 stalls, saturating 4-bit counter.
        do_reset();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        repeat (40) step();
        chk("sat_cnt4", 32'(sc3), 32'd15);
        chk("sat_cnt16", 32'(sc0), 32'd30);
        k = 0;
        while (st3 !== 1'b1 && k < 8) begin step(); k++; end
        chk("clr_stall_seen", 32'(st3), 32'd1);
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        step();
        chk("clr_cnt", 32'(sc3), 32'd0);
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (st3 !== 1'b1 && k < 8) begin step(); k++; end
        step();
        chk("clr_recount", 32'(sc3), 32'd1);

        // Random traffic over a small register set to keep hazards frequent.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            step();
        end
        idle();
        repeat (6) step();
        chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- In-order issue scheduler for the 32-bit pipeline. It sits between the instruction register/decode stage and the register file.
- Tracks destination registers of in-flight instructions over a fixed writeback latency.
- Stalls decode on read-after-write hazards.
- Generates the delayed writeback address/enable for the register file's write port. This replaces a plain RD delay chain and adds interlock and stall statistics.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- WB_LAT, 3, cycles from issue to register-file write (valid range 1..8).
- BYPASS_WB, 0, 1 = an entry in its writeback cycle does not cause a stall (regfile write-before-read).
- ZERO_REG, 1, 1 = register 0 is hardwired: never recorded as pending, never causes a stall.
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- rs1  in  ADDR_W  source 1 address
- rs2  in  ADDR_W  source 2 address
- use_rs1  in  1  instruction reads rs1
- use_rs2  in  1  instruction reads rs2
- rd  in  ADDR_W  destination address
- rd_we  in  1  instruction writes rd
- flush  in  1  branch/jump taken: cancel the decode-stage instruction this cycle
- stat_clr  in  1  synchronous clear of stall_count
- stall  out  1  hold PC and instruction register (combinational)
- issue_fire  out  1  instruction accepted into pipeline this cycle (combinational)
- wb_valid  out  1  register-file write enable (registered)
- wb_rd  out  ADDR_W  register-file write address (registered)
- busy  out  1  any pending write in flight (registered-derived)
- stall_count  out  CNT_W  saturating count of stall cycles (registered)

Behaviour:
- Reset: asynchronous, active-high.
  - All pipe entries are cleared to valid=0, rd=0.
  - wb_valid=0, wb_rd=0, busy=0, stall_count=0.
  - stall and issue_fire are 0 while reset is asserted.
- Storage: shift register of WB_LAT entries {v, rd}, entry 0 youngest, entry WB_LAT-1 oldest. It shifts every cycle unconditionally; stalls insert bubbles (v=0) at entry 0.
- Hazard check, combinational:
  - hit1 = use_rs1 and some entry k has v=1 and rd==rs1.
  - hit2 is defined the same way for rs2.
  - Entry WB_LAT-1 is excluded from the check when BYPASS_WB=1.
  - When ZERO_REG=1, a source address of 0 never hits.
- stall = issue_valid & ~flush & (hit1 | hit2).
- issue_fire = issue_valid & ~flush & ~stall.
- Entry 0 is loaded with v = issue_fire & rd_we & ~(ZERO_REG & rd==0) and rd = rd.
  - When v=0, rd is loaded as 0 so the outputs stay deterministic.
- Writeback outputs:
  - wb_valid = v of entry WB_LAT-1.
  - wb_rd = rd of entry WB_LAT-1, driven directly from the register.
  - Latency: an instruction firing in cycle N gives wb_valid=1 in cycle N+WB_LAT.
- busy = OR of all entry v bits.
- RAW timing with WB_LAT=3:
  - A producer fires in N and a consumer is presented in N+1.
  - BYPASS_WB=0: stall in N+1..N+3, consumer fires in N+4.
  - BYPASS_WB=1: stall in N+1..N+2, consumer fires in N+3.
- flush:
  - Overrides stall. The decode instruction is dropped and nothing is recorded.
  - In-flight entries are unaffected; they are older and always commit.
- stall_count:
  - Increments by 1 on each cycle with stall=1.
  - Saturates at all-ones.
  - stat_clr has priority over increment: the counter goes to 0 that cycle, and a coincident stall is not counted.
- Simultaneous events: a matching entry leaving the oldest stage in the same cycle does not release the stall until the next cycle; the check uses current register contents only.
- Reset mid-operation: all pending writes are discarded. No wb_valid pulse is produced after reset deasserts for instructions issued before reset.

Test Plan:
- Reset with entries loaded and counter=5 -> all outputs 0 immediately (async); no wb_valid in the 3 cycles after release.
- Back-to-back independent writes r1,r2,r3 firing cycles 1..3, no source overlap -> stall=0 throughout; wb_valid=1 with wb_rd=1,2,3 in cycles 4,5,6; busy falls in cycle 7.
- Producer writes r5 in cycle 1; consumer rs1=5, use_rs1=1 presented in cycle 2.
  - BYPASS_WB=0: stall in cycles 2,3,4, fire in cycle 5, stall_count=3.
  - BYPASS_WB=1: fire in cycle 4, stall_count=2.
- ZERO_REG=1: producer rd=0 with rd_we=1, then consumer rs2=0 -> no stall, wb_valid never asserts. ZERO_REG=0: 3 stall cycles.
- Consumer stalled on r7 and flush asserted in its second stall cycle -> stall=0 and issue_fire=0 that cycle; stall_count increments only for the first stall cycle.
- CNT_W=4 with a continuous hazard for 20 cycles -> stall_count reaches 15 and holds. stat_clr during stall -> 0, then 1 on the next stall cycle.
